// File: rtl/mc_ctrl_fsm_v2.sv
// rtl/mc_ctrl_fsm_v2.sv - multi-cycle RV32I control FSM with memory handshake timeout
// Optional cycle/instret counters are built when CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm_v2 #(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             IR_write,
    output logic             PC_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       ALU_src_a,
    output logic [1:0]       ALU_src_b,
    output logic [1:0]       ALU_op,
    output logic             is_ecall,
    output logic             illegal_inst,
    output logic             mem_err,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
        S_MW = 4'd4, S_WB = 4'd5, S_EX = 4'd6, S_EXI = 4'd7,
        S_RC = 4'd8, S_BR = 4'd9, S_BRT = 4'd10, S_JAL = 4'd11,
        S_JALR = 4'd12, S_HALT = 4'd13, S_ILL = 4'd14, S_ERR = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

    state_t          state, next;
    logic [TO_W-1:0] wait_cnt;
    logic            in_wait, timeout;

    assign in_wait = (state == S_IF) || (state == S_MR) || (state == S_MW);
    // A ready response on the limit cycle still advances normally.
    assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TO_LIM);

    always_comb begin
        next = state;
        case (state)
            S_IF:  if (mem_ready) next = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next = S_MA;
                    OP_R:              next = S_EX;
                    OP_I:              next = S_EXI;
                    OP_BRANCH:         next = S_BR;
                    OP_JAL:            next = S_JAL;
                    OP_JALR:           next = S_JALR;
                    OP_SYSTEM:         next = S_HALT;
                    default:           next = S_ILL;
                endcase
            end
            S_MA:  next = (opcode == OP_LOAD) ? S_MR : S_MW;
            S_MR:  if (mem_ready) next = S_WB;
            S_MW:  if (mem_ready) next = S_IF;
            S_EX, S_EXI: next = S_RC;
            S_BR:  next = bcond ? S_BRT : S_IF;
            S_WB, S_RC, S_BRT, S_JAL, S_JALR: next = S_IF;
            default: next = state;
        endcase
        if (timeout) next = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IF;
            wait_cnt <= '0;
        end else begin
            state    <= next;
            wait_cnt <= (in_wait && !mem_ready) ? wait_cnt + TO_W'(1) : '0;
        end
    end

    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        IR_write     = 1'b0;
        PC_write     = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 2'b00;
        ALU_src_a    = 2'b00;
        ALU_src_b    = 2'b00;
        ALU_op       = 2'b00;
        is_ecall     = 1'b0;
        illegal_inst = 1'b0;
        mem_err      = 1'b0;
        case (state)
            S_IF:   begin mem_read = 1'b1; IR_write = mem_ready; end
            S_ID:   begin ALU_src_b = 2'b01; PC_write = 1'b1; end
            S_MA:   begin ALU_src_a = 2'b01; ALU_src_b = 2'b10; end
            S_MR:   begin mem_read = 1'b1; i_or_d = 1'b1; end
            S_MW:   begin mem_write = 1'b1; i_or_d = 1'b1; end
            S_WB:   begin reg_write = 1'b1; mem_to_reg = 2'b01; end
            S_EX:   begin ALU_src_a = 2'b01; ALU_op = 2'b10; end
            S_EXI:  begin ALU_src_a = 2'b01; ALU_src_b = 2'b10; ALU_op = 2'b10; end
            S_RC:   reg_write = 1'b1;
            S_BR:   begin ALU_src_a = 2'b01; ALU_op = 2'b01; end
            S_BRT:  begin ALU_src_a = 2'b10; ALU_src_b = 2'b10; PC_write = 1'b1; end
            S_JAL: begin
                ALU_src_a = 2'b10; ALU_src_b = 2'b10;
                PC_write = 1'b1; reg_write = 1'b1; mem_to_reg = 2'b10;
            end
            S_JALR: begin
                ALU_src_a = 2'b01; ALU_src_b = 2'b10;
                PC_write = 1'b1; reg_write = 1'b1; mem_to_reg = 2'b10;
            end
            S_HALT: is_ecall = 1'b1;
            S_ILL:  illegal_inst = 1'b1;
            S_ERR:  mem_err = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (!(state == S_HALT || state == S_ILL || state == S_ERR))
                cyc_q <= cyc_q + CNT_W'(1);
            if (state != S_IF && next == S_IF)
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// tb/tb_mc_ctrl_fsm_v2.sv - randomized instruction-level check of mc_ctrl_fsm_v2 with MEM_TIMEOUT=4
module tb_mc_ctrl_fsm_v2;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, EC = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        bcond = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, i_or_d, IR_write, PC_write, reg_write;
    logic [1:0]  mem_to_reg, ALU_src_a, ALU_src_b, ALU_op;
    logic        is_ecall, illegal_inst, mem_err;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [15:0] obs;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int n_ret  = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_v2 #(.TO_W(8), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .IR_write(IR_write),
        .PC_write(PC_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_op(ALU_op),
        .is_ecall(is_ecall), .illegal_inst(illegal_inst), .mem_err(mem_err),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // {mem_read, mem_write, i_or_d, PC_write, reg_write, mem_to_reg, src_a, src_b, op, ecall, ill, err}
    assign obs = {mem_read, mem_write, i_or_d, PC_write, reg_write, mem_to_reg,
                  ALU_src_a, ALU_src_b, ALU_op, is_ecall, illegal_inst, mem_err};

    function automatic logic [15:0] exp_out(input int s);
        case (s)
            0:  return 16'b1_0_0_0_0_00_00_00_00_000;
            1:  return 16'b0_0_0_1_0_00_00_01_00_000;
            2:  return 16'b0_0_0_0_0_00_01_10_00_000;
            3:  return 16'b1_0_1_0_0_00_00_00_00_000;
            4:  return 16'b0_1_1_0_0_00_00_00_00_000;
            5:  return 16'b0_0_0_0_1_01_00_00_00_000;
            6:  return 16'b0_0_0_0_0_00_01_00_10_000;
            7:  return 16'b0_0_0_0_0_00_01_10_10_000;
            8:  return 16'b0_0_0_0_1_00_00_00_00_000;
            9:  return 16'b0_0_0_0_0_00_01_00_01_000;
            10: return 16'b0_0_0_1_0_00_10_10_00_000;
            11: return 16'b0_0_0_1_1_10_10_10_00_000;
            12: return 16'b0_0_0_1_1_10_01_10_00_000;
            13: return 16'b0_0_0_0_0_00_00_00_00_100;
            14: return 16'b0_0_0_0_0_00_00_00_00_010;
            default: return 16'b0_0_0_0_0_00_00_00_00_001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    endtask

    task automatic chk_perf(input string tag);
`ifdef CTRL_PERF_CNT_EN
        chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(cyc));
        chk({tag, "_instret_cnt"}, 64'(instret_cnt), 64'(n_ret));
`else
        chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        chk({tag, "_instret_cnt"}, 64'(instret_cnt), 64'd0);
`endif
    endtask

    // Called just after a negedge; drives one cycle, checks, returns after the next negedge.
    task automatic step(input logic [6:0] opc, input logic rdy, input logic bc, input int es, input string tag);
        opcode = opc; mem_ready = rdy; bcond = bc;
        #1;
        chk({tag, "_state"}, 64'(state_o), 64'(es));
        chk({tag, "_ctl"}, 64'(obs), 64'(exp_out(es)));
        chk({tag, "_ir_write"}, 64'(IR_write), 64'((es == 0) && rdy));
        if (es < 13) cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0; cyc = 0; n_ret = 0;
        #1;
        chk({tag, "_rst_state"}, 64'(state_o), 64'd0);
        chk({tag, "_rst_ctl"}, 64'(obs), 64'(exp_out(0)));
        chk_perf({tag, "_rst"});
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] opc, input logic bc, input int wif, input int wm, input int idx);
        int   sq[$];
        logic rq[$];
        chk_perf($sformatf("i%0d_pre", idx));
        for (int i = 0; i < wif; i++) begin sq.push_back(0); rq.push_back(1'b0); end
        sq.push_back(0); rq.push_back(1'b1);
        sq.push_back(1); rq.push_back(rbit());
        case (opc)
            LD: begin
                sq.push_back(2); rq.push_back(rbit());
                for (int i = 0; i < wm; i++) begin sq.push_back(3); rq.push_back(1'b0); end
                sq.push_back(3); rq.push_back(1'b1);
                sq.push_back(5); rq.push_back(rbit());
            end
            ST: begin
                sq.push_back(2); rq.push_back(rbit());
                for (int i = 0; i < wm; i++) begin sq.push_back(4); rq.push_back(1'b0); end
                sq.push_back(4); rq.push_back(1'b1);
            end
            RR: begin sq.push_back(6); rq.push_back(rbit()); sq.push_back(8); rq.push_back(rbit()); end
            RI: begin sq.push_back(7); rq.push_back(rbit()); sq.push_back(8); rq.push_back(rbit()); end
            BR: begin
                sq.push_back(9); rq.push_back(rbit());
                if (bc) begin sq.push_back(10); rq.push_back(rbit()); end
            end
            JL: begin sq.push_back(11); rq.push_back(rbit()); end
            default: begin sq.push_back(12); rq.push_back(rbit()); end
        endcase
        foreach (sq[i]) step(opc, rq[i], bc, sq[i], $sformatf("i%0d_c%0d", idx, i));
        n_ret++;
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{LD, ST, RR, RI, BR, JL, JR};
        @(negedge clk);
        do_reset("init");

        // Directed: ADD, LW with 3 wait cycles, BEQ both ways, JAL, JALR
        run_instr(RR, 1'b0, 0, 0, 1000);
        run_instr(LD, 1'b0, 0, 3, 1001);
        run_instr(BR, 1'b0, 1, 0, 1002);
        run_instr(BR, 1'b1, 0, 0, 1003);
        run_instr(JL, 1'b0, 2, 0, 1004);
        run_instr(JR, 1'b0, 0, 0, 1005);
        run_instr(ST, 1'b0, 3, 3, 1006);

        for (int n = 0; n < 150; n++)
            run_instr(ops[$urandom_range(0, 6)], rbit(), $urandom_range(0, 3), $urandom_range(0, 3), n);
        chk_perf("rand_end");

        // ECALL halts and stays halted with counters frozen
        do_reset("halt");
        step(EC, 1'b1, 1'b0, 0, "halt_if");
        step(EC, 1'b0, 1'b0, 1, "halt_id");
        for (int i = 0; i < 12; i++) step(7'($urandom), rbit(), rbit(), 13, $sformatf("halt_%0d", i));
        chk_perf("halt_end");

        // Unknown opcode traps
        do_reset("ill");
        step(7'b0000000, 1'b1, 1'b0, 0, "ill_if");
        step(7'b0000000, 1'b0, 1'b0, 1, "ill_id");
        for (int i = 0; i < 12; i++) step(7'($urandom), rbit(), rbit(), 14, $sformatf("ill_%0d", i));
        chk_perf("ill_end");

        // Fetch timeout after 4 stalled IF cycles
        do_reset("to_if");
        for (int i = 0; i < 4; i++) step(RR, 1'b0, 1'b0, 0, $sformatf("to_if_w%0d", i));
        for (int i = 0; i < 5; i++) step(RR, rbit(), 1'b0, 15, $sformatf("to_if_err%0d", i));
        chk_perf("to_if_end");

        // Ready on the limit cycle wins
        do_reset("lim");
        for (int i = 0; i < 3; i++) step(RR, 1'b0, 1'b0, 0, $sformatf("lim_w%0d", i));
        step(RR, 1'b1, 1'b0, 0, "lim_rdy");
        step(RR, 1'b0, 1'b0, 1, "lim_id");
        step(RR, 1'b0, 1'b0, 6, "lim_ex");
        step(RR, 1'b0, 1'b0, 8, "lim_rc");
        n_ret++;
        chk_perf("lim_end");

        // Load timeout in MR
        do_reset("to_mr");
        step(LD, 1'b1, 1'b0, 0, "to_mr_if");
        step(LD, 1'b0, 1'b0, 1, "to_mr_id");
        step(LD, 1'b0, 1'b0, 2, "to_mr_ma");
        for (int i = 0; i < 4; i++) step(LD, 1'b0, 1'b0, 3, $sformatf("to_mr_w%0d", i));
        step(LD, 1'b1, 1'b0, 15, "to_mr_err");

        // Reset in the middle of a store drops the pending write
        do_reset("mid");
        step(ST, 1'b1, 1'b0, 0, "mid_if");
        step(ST, 1'b0, 1'b0, 1, "mid_id");
        step(ST, 1'b0, 1'b0, 2, "mid_ma");
        step(ST, 1'b0, 1'b0, 4, "mid_mw");
        do_reset("mid_after");
        run_instr(RI, 1'b0, 1, 0, 2000);
        chk_perf("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm_v2.md
Name: mc_ctrl_fsm_v2

Overview:
Second-generation multi-cycle RV32I control FSM that sequences fetch/decode/execute/memory/writeback for the shared multi-cycle datapath. Compared with the first generation it adds a variable-latency memory handshake (mem_ready) with a parametrised timeout, and decodes only from the latched IR opcode. It also adds a split taken/not-taken branch path, JAL/JALR link writeback, a sticky halt, and an illegal-opcode trap. It sits between the IR opcode field and all datapath mux/enable controls.

Parameters:
TO_W, 8, width of memory-wait counter
MEM_TIMEOUT, 255, max cycles waiting on mem_ready before error; 0 disables timeout; must be < 2^TO_W
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
opcode  input  7  IR[6:0], valid from ID onward
bcond  input  1  ALU branch-compare result, valid in BR
mem_ready  input  1  memory completes the current access this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  0=PC address, 1=ALUOut address
IR_write  output  1  latch IR and old_pc
PC_write  output  1  PC update enable
reg_write  output  1  register-file write enable
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC (link)
ALU_src_a  output  2  00 PC, 01 rs1, 10 old_pc
ALU_src_b  output  2  00 rs2, 01 const 4, 10 imm
ALU_op  output  2  00 add, 01 branch compare, 10 funct-decoded
is_ecall  output  1  high while halted
illegal_inst  output  1  high while trapped
mem_err  output  1  high while in timeout error
state_o  output  4  current state encoding
cycle_cnt  output  CNT_W  see Optional Feature
instret_cnt  output  CNT_W  see Optional Feature

Behaviour:
- Encodings: IF=0, ID=1, MA=2, MR=3, MW=4, WB=5, EX=6, EXI=7, RC=8, BR=9, BRT=10, JAL=11, JALR=12, HALT=13, ILL=14, ERR=15.
- Outputs are 0 unless listed. They decode combinationally from state; IR_write is additionally gated by mem_ready.
- Reset: state=IF, wait counter=0, perf counters=0; outputs equal the IF values below with IR_write=0 unless mem_ready.
- IF: mem_read=1, i_or_d=0, IR_write=mem_ready. mem_ready -> ID; else stay.
- ID: src_a=00, src_b=01, op=00, PC_write=1 (PC<=PC+4). Next state by opcode:
  - 0000011/0100011 -> MA
  - 0110011 -> EX
  - 0010011 -> EXI
  - 1100011 -> BR
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1110011 -> HALT
  - any other -> ILL
- MA: src_a=01, src_b=10, op=00. Load -> MR; store -> MW.
- MR: mem_read=1, i_or_d=1. mem_ready -> WB; else stay.
- MW: mem_write=1, i_or_d=1. mem_ready -> IF; else stay.
- WB: reg_write=1, mem_to_reg=01 -> IF.
- EX: src_a=01, src_b=00, op=10 -> RC.
- EXI: src_a=01, src_b=10, op=10 -> RC.
- RC: reg_write=1, mem_to_reg=00 -> IF.
- BR: src_a=01, src_b=00, op=01. bcond=1 -> BRT; bcond=0 -> IF.
- BRT: src_a=10, src_b=10, op=00, PC_write=1 -> IF.
- JAL: src_a=10, src_b=10, op=00, PC_write=1, reg_write=1, mem_to_reg=10 -> IF. The link value is the current PC (old_pc+4), sampled on the same edge as the PC update.
- JALR: src_a=01, src_b=10, op=00, PC_write=1, reg_write=1, mem_to_reg=10 -> IF.
- HALT: is_ecall=1. ILL: illegal_inst=1. ERR: mem_err=1. All three are absorbing until reset.
- Wait counter:
  - Clears on entry to IF/MR/MW and whenever mem_ready=1.
  - Increments each cycle spent in IF/MR/MW with mem_ready=0.
  - When MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 with mem_ready=0, the next state is ERR.
  - mem_ready on the same cycle as the limit wins (normal advance).
- Reset mid-operation: forces IF on the next edge regardless of state, including HALT/ILL/ERR; no pending write survives.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle after reset, except in HALT/ILL/ERR, where it freezes.
  - instret_cnt increments on every edge where current state!=IF and next state==IF (one per retired instruction).
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports tied to 0 and no counter flops are built.

Test Plan:
- ADD (0110011), mem_ready=1 in IF -> states 0,1,6,8,0; reg_write=1 only in RC; mem_to_reg=00; instret +1.
- LW with mem_ready low 3 cycles in MR -> MR held 4 cycles, mem_read=1 and i_or_d=1 stable throughout; then WB with mem_to_reg=01.
- BEQ with bcond=0 -> BR->IF with no PC_write in BR. Rerun with bcond=1 -> BRT asserts PC_write=1, src_a=10, src_b=10.
- JAL then JALR -> PC_write=1, reg_write=1, mem_to_reg=10 in one cycle each; JALR drives src_a=01.
- ECALL, then opcode 0000000 after reset -> HALT (is_ecall sticky 10+ cycles), then ILL (illegal_inst sticky); a reset pulse returns state_o=0.
- MEM_TIMEOUT=4, mem_ready held 0 in IF -> ERR entered after 4 IF cycles, mem_err=1. Second run raising mem_ready on the 4th cycle -> ID, no error.
